// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle MIPS-I datapath.
// Contents: opcode/funct encodings, controller state enum, ALU op enum,
// and the decoded instruction class.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_op_t;

    typedef enum logic [2:0] {
        I_RTYPE, I_ADDI, I_LW, I_SW, I_BEQ, I_J
    } iclass_t;

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: architectural register file.
// Ports: clk/reset (sync, active-high, clears all registers),
//        ra1/ra2 -> rd1/rd2 combinational read ports,
//        we/wa/wd synchronous write port. Register 0 reads zero and
//        ignores writes.
module mc_regfile
    import mc_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: multi-cycle MIPS-I integer core (add/sub/and/or/slt,
// addi, lw, sw, beq, j) with req/ready instruction and data memory ports.
// Ports: clk, reset (sync, active-high);
//        imem_req/imem_addr/imem_ready/imem_rdata - instruction fetch;
//        dmem_req/dmem_we/dmem_addr/dmem_wdata/dmem_ready/dmem_rdata - data;
//        retire - pulse per completed instruction; pc_out - current PC;
//        halted - sticky, set after an illegal instruction is decoded.
module multicycle_datapath
    import mc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            retire,
    output logic [XLEN-1:0] pc_out,
    output logic            halted
);

    localparam int AW = $clog2(NREGS);

    state_t          state;
    iclass_t         cls;
    alu_op_t         alu_op;
    logic [XLEN-1:0] pc, a, b, imm, alu_out, mdr;
    logic [31:0]     ir;

    // Instruction fields
    logic [5:0]    op, funct;
    logic [AW-1:0] rs, rt, rd;
    assign op    = ir[31:26];
    assign funct = ir[5:0];
    assign rs    = ir[21 +: AW];
    assign rt    = ir[16 +: AW];
    assign rd    = ir[11 +: AW];

    // shamt and the unused high register-field bits carry no meaning here
    logic unused_ir;
    assign unused_ir = ^ir;

    // Register file
    logic [XLEN-1:0] rd1, rd2, wb_data;
    logic [AW-1:0]   wb_addr;
    logic            wb_en;

    assign wb_en   = (state == S_WB) && !reset;
    assign wb_addr = (cls == I_RTYPE) ? rd : rt;
    assign wb_data = (cls == I_LW) ? mdr : alu_out;

    mc_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rd1),
        .rd2   (rd2),
        .we    (wb_en),
        .wa    (wb_addr),
        .wd    (wb_data)
    );

    // Decode
    logic    dec_illegal;
    iclass_t dec_cls;
    alu_op_t dec_alu;

    always_comb begin
        dec_illegal = 1'b0;
        dec_cls     = I_ADDI;
        dec_alu     = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                dec_cls = I_RTYPE;
                case (funct)
                    FN_ADD:  dec_alu = ALU_ADD;
                    FN_SUB:  dec_alu = ALU_SUB;
                    FN_AND:  dec_alu = ALU_AND;
                    FN_OR:   dec_alu = ALU_OR;
                    FN_SLT:  dec_alu = ALU_SLT;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_ADDI: dec_cls = I_ADDI;
            OP_LW:   dec_cls = I_LW;
            OP_SW:   dec_cls = I_SW;
            OP_BEQ:  dec_cls = I_BEQ;
            OP_J:    dec_cls = I_J;
            default: dec_illegal = 1'b1;
        endcase
    end

    // ALU: second operand is rt for R-type, the sign-extended immediate otherwise
    logic [XLEN-1:0] opb, alu_res;
    assign opb = (cls == I_RTYPE) ? b : imm;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD: alu_res = a + opb;
            ALU_SUB: alu_res = a - opb;
            ALU_AND: alu_res = a & opb;
            ALU_OR:  alu_res = a | opb;
            ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(opb))};
            default: alu_res = '0;
        endcase
    end

    // Controller. pc already holds pc+4 by the time EXEC runs, so both branch
    // and jump targets are formed from it directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            pc       <= PC_RESET;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            imm      <= '0;
            alu_out  <= '0;
            mdr      <= '0;
            cls      <= I_ADDI;
            alu_op   <= ALU_ADD;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        ir       <= imem_rdata;
                        pc       <= pc + XLEN'(4);
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a      <= rd1;
                    b      <= rd2;
                    imm    <= {{(XLEN-16){ir[15]}}, ir[15:0]};
                    cls    <= dec_cls;
                    alu_op <= dec_alu;
                    if (dec_illegal) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (cls)
                        I_LW, I_SW: begin
                            alu_out  <= alu_res;
                            dmem_req <= 1'b1;
                            dmem_we  <= (cls == I_SW);
                            state    <= S_MEM;
                        end
                        I_BEQ: begin
                            if (a == b) pc <= pc + {imm[XLEN-3:0], 2'b00};
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                        I_J: begin
                            pc       <= {pc[XLEN-1:28], ir[25:0], 2'b00};
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                        default: begin
                            alu_out <= alu_res;
                            state   <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (cls == I_SW) begin
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end else begin
                            mdr   <= dmem_rdata;
                            state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Retire marks the last cycle of each instruction; a reset in that cycle
    // aborts it instead.
    assign retire = !reset &&
                    ((state == S_WB) ||
                     (state == S_EXEC && (cls == I_BEQ || cls == I_J)) ||
                     (state == S_MEM && dmem_ready && cls == I_SW));

    assign imem_addr  = pc;
    assign pc_out     = pc;
    assign dmem_addr  = alu_out;
    assign dmem_wdata = b;

endmodule

// File: tb/tb_multicycle_datapath.sv
module tb_multicycle_datapath;
    parameter int XLEN  = 32;
    parameter int NREGS = 32;
    localparam logic [XLEN-1:0] PC_RST = '0;

    localparam logic [5:0] OPR = 6'h00, OPJ = 6'h02, OPBEQ = 6'h04,
                           OPADDI = 6'h08, OPLW = 6'h23, OPSW = 6'h2B;
    localparam logic [5:0] FADD = 6'h20, FSUB = 6'h22, FAND = 6'h24,
                           FOR = 6'h25, FSLT = 6'h2A;
    localparam logic [31:0] NOP = 32'h2000_0000;  // addi $0,$0,0

    logic            clk, reset;
    logic            imem_req, imem_ready;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            dmem_req, dmem_we, dmem_ready;
    logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic            retire, halted;
    logic [XLEN-1:0] pc_out;

    multicycle_datapath #(.XLEN(XLEN), .NREGS(NREGS), .PC_RESET(PC_RST)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .retire(retire), .pc_out(pc_out), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]     imem [0:255];
    logic [XLEN-1:0] dmem [0:255];
    logic [XLEN-1:0] mdat [0:255];
    logic [XLEN-1:0] mreg [0:31];
    logic [XLEN-1:0] mpc;
    int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
    int checks = 0, errors = 0;
    int nret = 0, cnt = 0;
    bit first = 1, after_rst = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(logic [5:0] fn, int rd, int rs, int rt);
        logic [4:0] d, s, t;
        d = rd[4:0]; s = rs[4:0]; t = rt[4:0];
        return {OPR, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, int rt, int rs, int imm);
        logic [4:0] s, t;
        logic [15:0] i16;
        s = rs[4:0]; t = rt[4:0]; i16 = imm[15:0];
        return {op, s, t, i16};
    endfunction

    function automatic logic [31:0] enc_j(int tgt);
        logic [25:0] t26;
        t26 = tgt[25:0];
        return {OPJ, t26};
    endfunction

    function automatic logic [XLEN-1:0] sext(logic [15:0] v);
        return {{(XLEN-16){v[15]}}, v};
    endfunction

    function automatic bit is_illegal(logic [31:0] w);
        if (w[31:26] == OPR)
            return !(w[5:0] inside {FADD, FSUB, FAND, FOR, FSLT});
        return !(w[31:26] inside {OPJ, OPBEQ, OPADDI, OPLW, OPSW});
    endfunction

    // Cycles from fetch start to retire under the current wait-state setting
    function automatic int lat(logic [31:0] w);
        case (w[31:26])
            OPLW:      return 5 + iwait + dwait;
            OPSW:      return 4 + iwait + dwait;
            OPBEQ, OPJ: return 3 + iwait;
            default:   return 4 + iwait;
        endcase
    endfunction

    function automatic int ridx(logic [4:0] f);
        return int'(f) & (NREGS - 1);
    endfunction

    // Architectural model: execute one instruction at mpc
    task automatic model_step(input logic [31:0] w);
        logic [XLEN-1:0] va, vb, se, npc, res, ea;
        int rs, rt, rd;
        rs = ridx(w[25:21]); rt = ridx(w[20:16]); rd = ridx(w[15:11]);
        va = mreg[rs]; vb = mreg[rt]; se = sext(w[15:0]);
        npc = mpc + XLEN'(4);
        ea = va + se;
        res = '0;
        case (w[31:26])
            OPR: begin
                case (w[5:0])
                    FADD: res = va + vb;
                    FSUB: res = va - vb;
                    FAND: res = va & vb;
                    FOR:  res = va | vb;
                    default: res = ($signed(va) < $signed(vb)) ? XLEN'(1) : '0;
                endcase
                if (rd != 0) mreg[rd] = res;
            end
            OPADDI: if (rt != 0) mreg[rt] = ea;
            OPLW:   if (rt != 0) mreg[rt] = mdat[ea[9:2]];
            OPSW:   mdat[ea[9:2]] = vb;
            OPBEQ:  if (va == vb) npc = npc + (se << 2);
            default: npc = {npc[XLEN-1:28], w[25:0], 2'b00};
        endcase
        mpc = npc;
    endtask

    // Memory responder: ready after iwait/dwait cycles of a held request
    always @(posedge clk) begin
        #1;
        if (imem_req) begin
            if (icnt >= iwait) begin
                imem_ready = 1'b1; imem_rdata = imem[imem_addr[9:2]]; icnt = 0;
            end else begin
                imem_ready = 1'b0; icnt++;
            end
        end else begin
            imem_ready = 1'b0; icnt = 0;
        end
        if (dmem_req) begin
            if (dcnt >= dwait) begin
                dmem_ready = 1'b1;
                if (dmem_we) dmem[dmem_addr[9:2]] = dmem_wdata;
                dmem_rdata = dmem[dmem_addr[9:2]];
                dcnt = 0;
            end else begin
                dmem_ready = 1'b0; dcnt++;
            end
        end else begin
            dmem_ready = 1'b0; dcnt = 0;
        end
    end

    // Compare process: every cycle, DUT outputs versus the model
    always @(negedge clk) begin
        logic [31:0] w;
        logic [XLEN-1:0] ea;
        if (reset) begin
            chk("retire_in_reset", retire, 0);
            mpc = PC_RST;
            for (int i = 0; i < 32; i++) mreg[i] = '0;
            cnt = 0; first = 1; after_rst = 1;
        end else begin
            cnt++;
            w = imem[mpc[9:2]];
            if (after_rst) begin
                chk("rst_pc", pc_out, PC_RST);
                chk("rst_imem_req", imem_req, 0);
                chk("rst_dmem_req", dmem_req, 0);
                chk("rst_halted", halted, 0);
                after_rst = 0;
            end
            if (is_illegal(w)) begin
                chk("halted", halted, (cnt >= 3 + iwait + int'(first)) ? 1 : 0);
                chk("retire_illegal", retire, 0);
                if (halted) begin
                    chk("halt_imem_req", imem_req, 0);
                    chk("halt_dmem_req", dmem_req, 0);
                end
            end else begin
                chk("retire_timing", retire, (cnt == lat(w) + int'(first)) ? 1 : 0);
                chk("not_halted", halted, 0);
                if (imem_req) chk("imem_addr", imem_addr, mpc);
                if (dmem_req) begin
                    ea = mreg[ridx(w[25:21])] + sext(w[15:0]);
                    chk("dmem_addr", dmem_addr, ea);
                    chk("dmem_we", dmem_we, (w[31:26] == OPSW) ? 1 : 0);
                    if (w[31:26] == OPSW)
                        chk("dmem_wdata", dmem_wdata, mreg[ridx(w[20:16])]);
                end
                if (retire) begin
                    model_step(w);
                    nret++;
                    cnt = 0; first = 0;
                end
            end
        end
    end

    task automatic load_nops();
        for (int i = 0; i < 256; i++) imem[i] = NOP;
    endtask

    task automatic init_dmem();
        for (int i = 0; i < 256; i++) begin
            dmem[i] = XLEN'(32'hdead_0000 + i);
            mdat[i] = dmem[i];
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_ret(input int n);
        int start, t;
        start = nret; t = 0;
        while ((nret - start) < n && t < 3000) begin
            @(negedge clk); #1; t++;
        end
        if ((nret - start) < n) chk("retire_timeout", nret - start, n);
    endtask

    task automatic next_fetch(input string name, input logic [XLEN-1:0] exp);
        int t;
        t = 0;
        @(negedge clk); #1;
        while (!imem_req && t < 50) begin
            @(negedge clk); #1; t++;
        end
        chk(name, imem_addr, exp);
    endtask

    task automatic prog_a();
        load_nops();
        imem[0]  = enc_i(OPADDI, 1, 0, 5);
        imem[1]  = enc_i(OPADDI, 2, 0, -3);
        imem[2]  = enc_r(FADD, 3, 1, 2);
        imem[3]  = enc_i(OPSW, 3, 0, 8);
        imem[4]  = enc_i(OPLW, 4, 0, 8);
        imem[5]  = enc_i(OPSW, 4, 0, 12);
        imem[6]  = enc_i(OPADDI, 0, 0, 7);
        imem[7]  = enc_i(OPSW, 0, 0, 16);
        imem[8]  = enc_i(OPADDI, 5, 0, -1);
        imem[9]  = enc_i(OPADDI, 6, 0, 1);
        imem[10] = enc_r(FSLT, 7, 5, 6);
        imem[11] = enc_r(FSLT, 8, 6, 5);
        imem[12] = enc_i(OPSW, 7, 0, 20);
        imem[13] = enc_i(OPSW, 8, 0, 24);
        imem[14] = enc_r(FSUB, 9, 1, 2);
        imem[15] = enc_r(FAND, 10, 1, 2);
        imem[16] = enc_r(FOR, 11, 1, 2);
        imem[17] = enc_i(OPSW, 9, 0, 28);
        imem[18] = enc_i(OPSW, 10, 0, 32);
        imem[19] = enc_i(OPSW, 11, 0, 36);
        imem[20] = enc_j(20);
    endtask

    task automatic check_a(input string tag);
        logic [XLEN-1:0] allones;
        allones = '1;
        chk({tag, "_add_sw"}, dmem[2], 2);
        chk({tag, "_lw_sw"}, dmem[3], 2);
        chk({tag, "_r0"}, dmem[4], 0);
        chk({tag, "_slt_neg"}, dmem[5], 1);
        chk({tag, "_slt_swap"}, dmem[6], 0);
        chk({tag, "_sub"}, dmem[7], 8);
        chk({tag, "_and"}, dmem[8], 5);
        chk({tag, "_or"}, dmem[9], allones - XLEN'(2));
    endtask

    initial begin
        reset = 1'b1;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        imem_rdata = '0; dmem_rdata = '0;
        load_nops();
        init_dmem();

        // Program A, zero-wait fetch, 3-cycle data wait
        prog_a(); init_dmem(); iwait = 0; dwait = 3;
        do_reset();
        next_fetch("first_fetch", PC_RST);
        wait_ret(20);
        check_a("a0");

        // Same program with wait states on both ports
        prog_a(); init_dmem(); iwait = 2; dwait = 1;
        do_reset();
        wait_ret(20);
        check_a("a1");

        // Branch not taken at 0x10, then jump back to 0x10
        load_nops(); iwait = 0; dwait = 0;
        imem[0] = enc_i(OPADDI, 1, 0, 5);
        imem[1] = enc_i(OPADDI, 2, 0, 1);
        imem[4] = enc_i(OPBEQ, 2, 1, 5);
        imem[5] = enc_j(4);
        do_reset();
        wait_ret(5);
        next_fetch("beq_not_taken", XLEN'(32'h14));
        wait_ret(1);
        next_fetch("j_target", XLEN'(32'h10));

        // Branch taken to itself at 0x10
        imem[4] = enc_i(OPBEQ, 1, 1, -1);
        do_reset();
        wait_ret(5);
        next_fetch("beq_taken", XLEN'(32'h10));
        wait_ret(1);
        next_fetch("beq_taken_again", XLEN'(32'h10));

        // Illegal opcode halts; reset recovers
        load_nops();
        imem[0] = enc_i(OPADDI, 1, 0, 5);
        imem[1] = 32'hFC00_0000;
        do_reset();
        repeat (20) @(negedge clk);
        #1 chk("halted_sticky", halted, 1);
        chk("halt_no_fetch", imem_req, 0);
        imem[1] = NOP;
        do_reset();
        chk("halt_cleared", halted, 0);
        next_fetch("fetch_after_halt", PC_RST);

        // Reset during a store's data wait: no write, no retire
        load_nops(); init_dmem(); iwait = 0; dwait = 10;
        imem[0] = enc_i(OPADDI, 3, 0, 9);
        imem[1] = enc_i(OPSW, 3, 0, 8);
        imem[2] = enc_j(2);
        do_reset();
        wait_ret(1);
        begin
            int t;
            t = 0;
            while (!dmem_req && t < 50) begin
                @(negedge clk); #1; t++;
            end
            chk("sw_req_seen", dmem_req, 1);
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; dwait = 0;
        @(negedge clk); #1;
        chk("sw_abort_req", dmem_req, 0);
        chk("sw_abort_mem", dmem[2], XLEN'(32'hdead_0002));
        wait_ret(3);
        chk("sw_after_abort", dmem[2], 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Parametrised multi-cycle successor to the single-cycle MIPS datapath. Executes a MIPS-I integer subset: R-type add/sub/and/or/slt, addi, lw, sw, beq, j. A state machine drives it and talks to external instruction and data memories through req/ready handshakes, so memory may take wait states. It is the top of the core; the memories and bench sit outside.

## Interface
Parameters:
- XLEN, 32, datapath/PC width; legal values ≥ 32. Instruction encoding stays 32-bit.
- NREGS, 32, architectural registers; power of two, ≤ 32. Register fields use the low log2(NREGS) bits.
- PC_RESET, 0, PC value after reset.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  XLEN  fetch address (= pc).
- imem_ready  in  1  fetch data valid this cycle.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  XLEN  ALU result.
- dmem_wdata  out  XLEN  rt value.
- dmem_ready  in  1  access complete / load data valid.
- dmem_rdata  in  XLEN  load data.
- retire  out  1  one-cycle pulse per completed instruction.
- pc_out  out  XLEN  current PC (debug).
- halted  out  1  illegal opcode/funct seen; sticky until reset.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE → FETCH unconditionally.
- FETCH: imem_req=1. Stays in FETCH while imem_ready=0. On ready: latch IR, set pc ← pc+4, go to DECODE.
- DECODE: read rs/rt into A/B, sign-extend imm16 to XLEN. Illegal opcode or funct → HALT.
- EXEC, by instruction:
  - R-type/addi: compute result → WB.
  - lw/sw: addr = A + sext(imm) → MEM.
  - beq: if A==B, pc ← pc + (sext(imm)<<2); → FETCH with retire.
  - j: pc ← {pc[XLEN-1:28], target26, 2'b00}; → FETCH with retire.
- MEM: dmem_req=1, dmem_we=(sw). Held until dmem_ready. sw → FETCH with retire; lw latches rdata → WB.
- WB: write rd (R-type) or rt (addi/lw); → FETCH with retire.
- Register 0 reads 0; writes to it are dropped.
- slt is signed over XLEN. All arithmetic wraps mod 2^XLEN, no overflow trap. PC wraps the same way.
- req outputs and addresses stay stable while req is high and ready is low.
- Reset values: state IDLE, pc=PC_RESET, all registers 0, imem_req=dmem_req=dmem_we=retire=halted=0.
- Reset at any time, including mid-handshake, aborts the instruction; no register or memory write occurs in that cycle.

## Timing
- Zero-wait memory latency in cycles from FETCH entry to retire: R-type/addi 4, lw 5, sw 4, beq/j 3. Each wait cycle adds one.
- retire is asserted in the final-state cycle (WB, MEM-with-ready for sw, EXEC for beq/j).
- Register write takes effect at the edge leaving WB, so the next DECODE sees it; no bypassing is needed.
- halted rises the cycle after DECODE of the illegal word. HALT issues no requests.

## Structure
- Package mc_pkg: opcode/funct localparams, state enum, ALU op enum.
- Sub-module mc_regfile: parametrised in XLEN and NREGS; 2 combinational read ports, 1 synchronous write port, r0 hardwired to zero.
- ALU and control stay inline in multicycle_datapath.

## Test plan
- Reset then addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2 with zero-wait memory → $3=2, retire every 4 cycles, first imem_addr=PC_RESET.
- sw $3,8($0) then lw $4,8($0) with dmem_ready delayed 3 cycles → dmem_req held for 4 cycles with stable addr=8 and wdata=2; $4=2; lw total 8 cycles.
- beq $1,$1,-1 at 0x10 → next fetch at 0x10. bne-style not-taken case (beq $1,$2) → next fetch 0x14.
- slt with $1=-1, $2=1 → 1; swapped operands → 0; addi $0,$0,7 → $0 still reads 0.
- Illegal opcode 0x3F → halted=1 next cycle, no further requests; reset clears it and fetch resumes at PC_RESET.
- Assert reset during a MEM wait for sw → dmem_req drops after the edge, no retire; XLEN=64, NREGS=16 build passes the same program.
